// File: rtl/led_display_hub75_driver_pkg.sv
// Shared row-stream types used by the pattern generator and the HUB75 driver,
// plus the driver's state encoding and pixel-column helper.
package led_display_hub75_driver_pkg;

    localparam int GL_NUM_COL_PIXELS   = 64;
    localparam int GL_NUM_COL_PIXELS_W = $clog2(GL_NUM_COL_PIXELS);
    localparam int GL_RGB_COL_W        = 3;
    localparam int GL_RGB_ROW_W        = 2 * GL_RGB_COL_W * GL_NUM_COL_PIXELS;
    localparam int GL_HUB75_RGB_W      = 6;

    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] red;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] blue;
    } rgb_half_t;

    typedef struct packed {
        rgb_half_t top;
        rgb_half_t bot;
    } rgb_row_t;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } hub75_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Panel pin order is {b2,g2,r2,b1,g1,r1}: bottom half in the upper three bits.
    function automatic logic [GL_HUB75_RGB_W-1:0] hub75_column(
        input rgb_row_t                       row,
        input logic [GL_NUM_COL_PIXELS_W-1:0] k
    );
        return {row.bot.blue[k], row.bot.green[k], row.bot.red[k],
                row.top.blue[k], row.top.green[k], row.top.red[k]};
    endfunction

endpackage

// File: rtl/led_display_hub75_shifter.sv
// Serialises one captured row onto the HUB75 data/clock pins, column N-1 first.
// A start pulse loads the row; done pulses on the final high-phase cycle.
module led_display_hub75_shifter
    import led_display_hub75_driver_pkg::*;
#(
    parameter int SCLK_HALF = 2,
    parameter int CNT_W     = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  rgb_row_t                  row_i,
    output logic                      done_o,
    output logic                      hub_clk_o,
    output logic [GL_HUB75_RGB_W-1:0] hub_rgb_o
);

    localparam logic [CNT_W-1:0]               HALF_LAST = CNT_W'(SCLK_HALF - 1);
    localparam logic [GL_NUM_COL_PIXELS_W-1:0] LAST_COL  = GL_NUM_COL_PIXELS_W'(GL_NUM_COL_PIXELS - 1);

    rgb_row_t                       row_q;
    logic [GL_NUM_COL_PIXELS_W-1:0] col_q;
    logic [CNT_W-1:0]               half_q;
    logic                           active_q;
    logic                           hub_clk_q;
    logic [GL_HUB75_RGB_W-1:0]      hub_rgb_q;
    logic                           half_end;

    assign half_end  = (half_q == HALF_LAST);
    assign done_o    = active_q && half_end && hub_clk_q && (col_q == '0);
    assign hub_clk_o = hub_clk_q;
    assign hub_rgb_o = hub_rgb_q;

    // NOTE: the row buffer is pure datapath, loaded before it is ever read, so it
    // is deliberately left out of reset; only control and pin state are cleared.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            active_q  <= 1'b0;
            col_q     <= '0;
            half_q    <= '0;
            hub_clk_q <= 1'b0;
            hub_rgb_q <= '0;
        end else if (start_i) begin
            active_q  <= 1'b1;
            row_q     <= row_i;
            col_q     <= LAST_COL;
            half_q    <= '0;
            hub_clk_q <= 1'b0;
            hub_rgb_q <= hub75_column(row_i, LAST_COL);
        end else if (active_q) begin
            if (!half_end) begin
                half_q <= half_q + 1'b1;
            end else begin
                half_q <= '0;
                if (!hub_clk_q) begin
                    hub_clk_q <= 1'b1;
                end else begin
                    hub_clk_q <= 1'b0;
                    if (col_q == '0) begin
                        active_q <= 1'b0;
                    end else begin
                        col_q     <= col_q - 1'b1;
                        hub_rgb_q <= hub75_column(row_q, col_q - 1'b1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/led_display_hub75_driver.sv
// HUB75 row driver: accept a row, shift it out, blank, latch, then display.
// Optional LED_DISPLAY_HUB75_BRIGHTNESS_EN adds brightness_in to shorten OE-on time.
module led_display_hub75_driver
    import led_display_hub75_driver_pkg::*;
#(
    parameter int SYS_CLK_FREQ   = 100_000_000,
    parameter int SCLK_HALF      = 2,
    parameter int BLANK_CYCLES   = 4,
    parameter int LATCH_CYCLES   = 2,
    parameter int DISPLAY_CYCLES = 2000
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  rgb_row_t                  row_in,
    input  logic [3:0]                row_address_in,
    input  logic                      row_valid_in,
`ifdef LED_DISPLAY_HUB75_BRIGHTNESS_EN
    input  logic [7:0]                brightness_in,
`endif
    output logic                      row_ready_out,
    output logic                      hub_clk_out,
    output logic [GL_HUB75_RGB_W-1:0] hub_rgb_out,
    output logic                      hub_lat_out,
    output logic                      hub_oe_n_out,
    output logic [3:0]                hub_addr_out,
    output logic                      busy_out
);

    localparam int CNT_W = $clog2(max4(2 * SCLK_HALF, BLANK_CYCLES, LATCH_CYCLES, DISPLAY_CYCLES) + 1);
    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST   = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] DISPLAY_LAST = CNT_W'(DISPLAY_CYCLES - 1);

    hub75_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       addr_buf_q;
    logic [3:0]       hub_addr_q, hub_addr_d;
    logic             ready_q, ready_d;
    logic             lat_q, lat_d;
    logic             oe_n_q, oe_n_d;
    logic             transfer;
    logic             shift_done;
    logic             oe_on;

    assign transfer = row_valid_in && ready_q;

    led_display_hub75_shifter #(
        .SCLK_HALF (SCLK_HALF),
        .CNT_W     (CNT_W)
    ) u_shifter (
        .clk_i     (clk_in),
        .reset_i   (reset_in),
        .start_i   (transfer),
        .row_i     (row_in),
        .done_o    (shift_done),
        .hub_clk_o (hub_clk_out),
        .hub_rgb_o (hub_rgb_out)
    );

`ifdef LED_DISPLAY_HUB75_BRIGHTNESS_EN
    logic [CNT_W+7:0] on_prod;
    logic [CNT_W-1:0] on_lim_q, on_lim;

    // Full-width product so the >>8 keeps every significant bit.
    always_comb begin
        on_prod = (CNT_W+8)'(DISPLAY_CYCLES) * (CNT_W+8)'(brightness_in);
        on_lim  = (state_q == LATCH) ? CNT_W'(on_prod >> 8) : on_lim_q;
        oe_on   = (cnt_d < on_lim);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            on_lim_q <= '0;
        end else if (state_q == LATCH && state_d == DISPLAY) begin
            on_lim_q <= on_lim;
        end
    end
`else
    assign oe_on = 1'b1;
`endif

    // NOTE: every always_comb output gets a default first, so no path can hold a
    // stale value and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    if (transfer) state_d = SHIFT;
            SHIFT:   if (shift_done) begin state_d = BLANK; cnt_d = '0; end
            BLANK:   if (cnt_q == BLANK_LAST) begin state_d = LATCH; cnt_d = '0; end
                     else cnt_d = cnt_q + 1'b1;
            LATCH:   if (cnt_q == LATCH_LAST) begin state_d = DISPLAY; cnt_d = '0; end
                     else cnt_d = cnt_q + 1'b1;
            DISPLAY: if (cnt_q == DISPLAY_LAST) begin state_d = IDLE; cnt_d = '0; end
                     else cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
        ready_d    = (state_d == IDLE);
        lat_d      = (state_d == LATCH);
        oe_n_d     = !(state_d == DISPLAY && oe_on);
        hub_addr_d = (state_q == SHIFT && state_d == BLANK) ? addr_buf_q : hub_addr_q;
    end

    // NOTE: all state and pin registers update with <= so every process sees the
    // pre-edge values of its neighbours.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_buf_q <= '0;
            hub_addr_q <= '0;
            ready_q    <= 1'b0;
            lat_q      <= 1'b0;
            oe_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hub_addr_q <= hub_addr_d;
            ready_q    <= ready_d;
            lat_q      <= lat_d;
            oe_n_q     <= oe_n_d;
            if (transfer) addr_buf_q <= row_address_in;
        end
    end

    always_ff @(posedge clk_in) begin
        assert (SYS_CLK_FREQ > 0 && SCLK_HALF >= 1 && BLANK_CYCLES >= 1 &&
                LATCH_CYCLES >= 1 && DISPLAY_CYCLES >= 1);
    end

    assign row_ready_out = ready_q;
    assign hub_lat_out   = lat_q;
    assign hub_oe_n_out  = oe_n_q;
    assign hub_addr_out  = hub_addr_q;
    assign busy_out      = (state_q != IDLE);

endmodule

// File: tb/tb_led_display_hub75_driver.sv
// Scoreboard bench for the HUB75 driver: expected columns queued at each transfer,
// popped on every hub_clk rising edge; per-row timing checked against fixed offsets.
module tb_led_display_hub75_driver;
    import led_display_hub75_driver_pkg::*;

    localparam int SCLK_HALF      = 1;
    localparam int BLANK_CYCLES   = 2;
    localparam int LATCH_CYCLES   = 1;
    localparam int DISPLAY_CYCLES = 100;
    localparam int SHIFT_LEN      = 2 * SCLK_HALF * GL_NUM_COL_PIXELS;   // 128
    localparam int LAT_AT         = 1 + SHIFT_LEN + BLANK_CYCLES;        // 131
    localparam int OE_AT          = LAT_AT + LATCH_CYCLES;               // 132
    localparam int PERIOD         = OE_AT + DISPLAY_CYCLES;              // 232

    logic                      clk_in = 1'b0;
    logic                      reset_in = 1'b1;
    rgb_row_t                  row_in = '0;
    logic [3:0]                row_address_in = '0;
    logic                      row_valid_in = 1'b0;
    logic                      row_ready_out;
    logic                      hub_clk_out;
    logic [GL_HUB75_RGB_W-1:0] hub_rgb_out;
    logic                      hub_lat_out;
    logic                      hub_oe_n_out;
    logic [3:0]                hub_addr_out;
    logic                      busy_out;
`ifdef LED_DISPLAY_HUB75_BRIGHTNESS_EN
    logic [7:0]                brightness_in = 8'd255;
`endif

    led_display_hub75_driver #(
        .SYS_CLK_FREQ   (100_000_000),
        .SCLK_HALF      (SCLK_HALF),
        .BLANK_CYCLES   (BLANK_CYCLES),
        .LATCH_CYCLES   (LATCH_CYCLES),
        .DISPLAY_CYCLES (DISPLAY_CYCLES)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .row_in         (row_in),
        .row_address_in (row_address_in),
        .row_valid_in   (row_valid_in),
`ifdef LED_DISPLAY_HUB75_BRIGHTNESS_EN
        .brightness_in  (brightness_in),
`endif
        .row_ready_out  (row_ready_out),
        .hub_clk_out    (hub_clk_out),
        .hub_rgb_out    (hub_rgb_out),
        .hub_lat_out    (hub_lat_out),
        .hub_oe_n_out   (hub_oe_n_out),
        .hub_addr_out   (hub_addr_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] px(input rgb_row_t r, input int k);
        return {r.bot.blue[k], r.bot.green[k], r.bot.red[k],
                r.top.blue[k], r.top.green[k], r.top.red[k]};
    endfunction

    function automatic rgb_row_t rand_row();
        logic [GL_RGB_ROW_W-1:0] v;
        for (int i = 0; i < GL_RGB_ROW_W / 32; i++) v[i*32 +: 32] = $urandom();
        return rgb_row_t'(v);
    endfunction

    logic [5:0] exp_q[$];
    logic [5:0] exp_first, exp_last;
    logic [3:0] exp_addr;
    int  exp_oe;
    int  cyc = 0, last_xfer = 0, xfer_cnt = 0;
    int  rel = 0, edges = 0, lat_cnt = 0, lat_pos = 0, oe_cnt = 0, oe_first = 0, ready_bad = 0;
    bit  mon_en = 0, row_active = 0, bp_en = 0, prev_bp = 0;
    logic clk_prev = 1'b0;

    // Transfer detection: queue the expected columns from the stimulus just driven.
    always @(posedge clk_in) begin
        cyc++;
        if (mon_en && row_valid_in && row_ready_out) begin
            if (bp_en && prev_bp) check("period", cyc - last_xfer, PERIOD);
            prev_bp   = bp_en;
            last_xfer = cyc;
            xfer_cnt++;
            for (int k = GL_NUM_COL_PIXELS - 1; k >= 0; k--) exp_q.push_back(px(row_in, k));
            exp_first = px(row_in, GL_NUM_COL_PIXELS - 1);
            exp_last  = px(row_in, 0);
            exp_addr  = row_address_in;
`ifdef LED_DISPLAY_HUB75_BRIGHTNESS_EN
            exp_oe    = (DISPLAY_CYCLES * int'(brightness_in)) >> 8;
`else
            exp_oe    = DISPLAY_CYCLES;
`endif
            rel = 0; edges = 0; lat_cnt = 0; lat_pos = 0;
            oe_cnt = 0; oe_first = 0; ready_bad = 0;
            row_active = 1;
        end
    end

    always @(negedge clk_in) begin
        if (mon_en && row_active) begin
            rel++;
            if (hub_clk_out && !clk_prev) begin
                edges++;
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else check("rgb_col", hub_rgb_out, exp_q.pop_front());
            end
            if (rel == 1) check("rgb_first", hub_rgb_out, exp_first);
            if (rel == SHIFT_LEN - 1) check("rgb_last", hub_rgb_out, exp_last);
            if (rel == SHIFT_LEN + 1) check("addr", hub_addr_out, exp_addr);
            if (hub_lat_out) begin lat_cnt++; lat_pos = rel; end
            if (!hub_oe_n_out) begin
                if (oe_cnt == 0) oe_first = rel;
                oe_cnt++;
            end
            if (row_ready_out && (rel < PERIOD || busy_out)) ready_bad++;
            if (rel == PERIOD) begin
                check("clk_edges", edges, SHIFT_LEN / (2 * SCLK_HALF));
                check("lat_cnt", lat_cnt, LATCH_CYCLES);
                check("lat_pos", lat_pos, LAT_AT);
                check("oe_cnt", oe_cnt, exp_oe);
                if (exp_oe > 0) check("oe_first", oe_first, OE_AT);
                check("ready_idle", row_ready_out, 1);
                check("ready_busy", ready_bad, 0);
                row_active = 0;
            end
        end
        clk_prev = hub_clk_out;
    end

    task automatic wait_xfer(input int target);
        for (int i = 0; i < 400 && xfer_cnt < target; i++) @(negedge clk_in);
        if (xfer_cnt < target) check("xfer_timeout", xfer_cnt, target);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && row_active; i++) @(negedge clk_in);
        if (row_active) check("idle_timeout", 1, 0);
    endtask

    task automatic send(input logic [3:0] a);
        int base;
        base = xfer_cnt;
        row_address_in = a;
        row_valid_in   = 1'b1;
        wait_xfer(base + 1);
        row_valid_in   = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_ready"}, row_ready_out, 0);
        check({pfx, "_oe_n"}, hub_oe_n_out, 1);
        check({pfx, "_clk"}, hub_clk_out, 0);
        check({pfx, "_rgb"}, hub_rgb_out, 0);
        check({pfx, "_lat"}, hub_lat_out, 0);
        check({pfx, "_addr"}, hub_addr_out, 0);
        check({pfx, "_busy"}, busy_out, 0);
    endtask

`ifdef LED_DISPLAY_HUB75_BRIGHTNESS_EN
    logic [7:0] btab [3] = '{8'd128, 8'd0, 8'd255};
`endif

    initial begin
        int base;
        repeat (3) @(negedge clk_in);
        check_reset_values("init");
        reset_in = 1'b0;
        @(negedge clk_in);
        check("init_release_ready", row_ready_out, 1);
        mon_en = 1;

        // Single row: top red at both ends of the row.
        row_in = '0;
        row_in.top.red = 64'h8000_0000_0000_0001;
        send(4'd5);
        wait_idle();
        check("idle_addr_hold", hub_addr_out, 5);
        check("idle_rgb_hold", hub_rgb_out, 6'b000001);

        // Reset held for three cycles in the middle of SHIFT.
        row_in = rand_row();
        send(4'd9);
        repeat (20) @(negedge clk_in);
        mon_en = 0; row_active = 0; exp_q.delete();
        reset_in = 1'b1;
        @(negedge clk_in);
        check_reset_values("midrst");
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;
        check("midrst_ready_hold", row_ready_out, 0);
        @(negedge clk_in);
        check("midrst_release_ready", row_ready_out, 1);
        mon_en = 1;

        // Bottom half green only.
        row_in = '0;
        row_in.bot.green = '1;
        send(4'd10);
        wait_idle();

        // Capture isolation: scramble inputs every cycle after the transfer.
        row_in = rand_row();
        send(4'd3);
        for (int i = 0; i < 140; i++) begin
            @(negedge clk_in);
            row_in = rand_row();
            row_address_in = 4'($urandom());
        end
        wait_idle();

        // Back-pressure: valid held across three rows.
        bp_en = 1;
        row_in = rand_row();
        row_address_in = 4'd12;
        row_valid_in = 1'b1;
        base = xfer_cnt;
        for (int i = 0; i < 3; i++) begin
`ifdef LED_DISPLAY_HUB75_BRIGHTNESS_EN
            brightness_in = btab[i];
`endif
            wait_xfer(base + i + 1);
            row_in = rand_row();
            row_address_in = 4'(i);
            if (i == 2) row_valid_in = 1'b0;
            else repeat (150) @(negedge clk_in);
        end
        wait_idle();
        bp_en = 0;

        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
